// File: rtl/mult_control_path.sv
// mult_control_path: valid/ready FSM sequencing a shift-add multiplier datapath
module mult_control_path #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(2*WIDTH+2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    sel,
  input  logic          b_0,
  input  logic          count_0,
  output logic          busy,
  output logic [CW-1:0] cycles
);
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  assign in_ready = state == IDLE && !rst;
  assign busy = state != IDLE && !rst;
  // DONE keeps shifting: p is untouched by a shift, so r_out stays stable
  always_comb sel = rst ? 2'b11 : state == IDLE ? (in_valid ? 2'b00 : 2'b11) : state == ADD ? 2'b01 : 2'b10;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      cycles <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= b_0 ? ADD : SHIFT;
          cnt <= CW'(1);
        end
        ADD: begin
          state <= SHIFT;
          cnt <= cnt + CW'(1);
        end
        SHIFT: begin
          cnt <= cnt + CW'(1);
          if (count_0) begin
            state <= DONE;
            out_valid <= 1'b1;
            cycles <= cnt + CW'(1);
          end else state <= b_0 ? ADD : SHIFT;
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_control_path.sv
// tb_mult_control_path: controller plus behavioural shift-add datapath, checked against a*b and W+1+popcount(b)
module tb_mult_control_path;
  localparam int W = 8;
  localparam int CW = $clog2(2*W+2);
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, b_0, count_0, in_ready, out_valid, busy;
  logic [1:0] sel;
  logic [CW-1:0] cycles;
  logic [W-1:0] a_in = 0, b_in = 0;
  logic [2*W-1:0] p_r, a_r, r_out;
  logic [W-1:0] b_r, bn;
  logic [3:0] n_r, nn;
  int total = 0, bad = 0;

  mult_control_path #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .sel(sel),
    .b_0(b_0), .count_0(count_0), .busy(busy), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // datapath: p accumulates a, a shifts left, b shifts right, n counts shifts down
  always_comb begin
    bn = b_r;
    nn = n_r;
    if (sel == 2'b00) begin bn = b_in; nn = 4'(W); end
    else if (sel == 2'b10) begin bn = b_r >> 1; nn = n_r - 4'd1; end
    else if (sel == 2'b11) begin bn = '0; nn = '0; end
  end
  assign b_0 = bn[0];
  assign count_0 = nn == 0;
  assign r_out = p_r;
  always_ff @(posedge clk) begin
    b_r <= bn;
    n_r <= nn;
    case (sel)
      2'b00: begin p_r <= '0; a_r <= {{W{1'b0}}, a_in}; end
      2'b01: p_r <= p_r + a_r;
      2'b10: a_r <= a_r << 1;
      default: begin p_r <= '0; a_r <= '0; end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int stall, input bit hold,
                     input bit b2b, input logic [15:0] exp_p, input int exp_c);
    logic [1:0] q[$];
    int waited, lat, idx;
    bit seq_ok;
    q = {2'b00};
    for (int i = 0; i < W; i++) begin
      if (b[i]) q.push_back(2'b01);
      q.push_back(2'b10);
    end
    waited = 0;
    @(negedge clk);
    a_in = a; b_in = b; in_valid = 1; out_ready = (stall == 0);
    #1;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
      #1;
    end
    chk("accept_ready", in_ready, 1);
    if (b2b) chk("b2b_wait", waited, 0);
    lat = 0; idx = 0; seq_ok = 1;
    while (!out_valid && lat < 60) begin
      if (idx >= q.size() || sel !== q[idx]) seq_ok = 0;
      idx++;
      lat++;
      @(negedge clk);
      in_valid = hold;
      a_in = W'($urandom);
      b_in = W'($urandom);
      #1;
    end
    chk("sel_seq", 32'(seq_ok && idx == q.size()), 1);
    chk("latency", lat, exp_c);
    chk("product", r_out, exp_p);
    chk("cycles", cycles, exp_c);
    chk("busy_done", busy, 1);
    for (int k = 1; k <= stall; k++) begin
      @(negedge clk);
      out_ready = (k == stall);
      in_valid = k[0] | hold;
      #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_sel", sel, 2'b10);
      chk("stall_r", r_out, exp_p);
      chk("stall_ready", in_ready, 0);
    end
    if (!hold) begin
      @(negedge clk);
      in_valid = 0;
      out_ready = 1'($urandom);
      #1;
      chk("post_valid", out_valid, 0);
      chk("post_ready", in_ready, 1);
      chk("post_sel", sel, 2'b11);
      chk("post_busy", busy, 0);
    end
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    int stall;
    bit hold, b2b;
    logic [15:0] prod;
    int cyc;
  } vec_t;

  vec_t vt[6];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int shifts, g;
    logic [W-1:0] ra, rb;
    vt[0] = '{8'd3, 8'd5, 0, 0, 0, 16'd15, 11};
    vt[1] = '{8'd200, 8'd0, 0, 0, 0, 16'd0, 9};
    vt[2] = '{8'd255, 8'd255, 0, 0, 0, 16'd65025, 17};
    vt[3] = '{8'd3, 8'd5, 5, 0, 0, 16'd15, 11};
    vt[4] = '{8'd7, 8'd9, 0, 1, 0, 16'd63, 11};
    vt[5] = '{8'd255, 8'd2, 0, 0, 1, 16'd510, 10};
    rst = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_ready", in_ready, 0);
      chk("rst_sel", sel, 2'b11);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
    end
    chk("rst_cycles", cycles, 0);
    @(negedge clk);
    rst = 0; in_valid = 0;
    #1;
    chk("rel_ready", in_ready, 1);
    chk("rel_sel", sel, 2'b11);
    for (int i = 0; i < 6; i++)
      run(vt[i].a, vt[i].b, vt[i].stall, vt[i].hold, vt[i].b2b, vt[i].prod, vt[i].cyc);
    @(negedge clk);
    a_in = 8'd100; b_in = 8'd100; in_valid = 1; out_ready = 1;
    #1;
    chk("abort_accept", in_ready, 1);
    shifts = 0; g = 0;
    while (shifts < 4 && g < 40) begin
      @(negedge clk);
      in_valid = 0;
      #1;
      if (sel == 2'b10) shifts++;
      g++;
    end
    chk("abort_shifts", shifts, 4);
    rst = 1;
    #1;
    chk("abort_sel", sel, 2'b11);
    chk("abort_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_idle", in_ready, 1);
    chk("abort_cycles", cycles, 0);
    run(8'd12, 8'd12, 0, 0, 0, 16'd144, 11);
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run(ra, rb, $urandom_range(0, 3), 0, 0, 16'(ra) * 16'(rb), W + 1 + $countones(rb));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
